// File: rtl/sma_signal_engine.sv
// Moving-average crossover/confluence engine: scores fast-vs-slow spread and slope agreement,
// then drives a FLAT/LONG/SHORT position FSM with a post-transition cooldown.
module sma_signal_engine #(
  parameter int DATA_W       = 8,
  parameter int N_CH         = 6,
  parameter int SCORE_THRESH = 77,
  parameter int CONF_THRESH  = 3,
  parameter int COOLDOWN     = 4,
  localparam int SCORE_W     = DATA_W + 1 + $clog2(N_CH / 2) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [N_CH*DATA_W-1:0]    ma_data,
  output logic                      out_valid,
  output logic                      buy_pulse,
  output logic                      sell_pulse,
  output logic [1:0]                position,
  output logic signed [SCORE_W-1:0] score
);

  localparam int HALF   = N_CH / 2;
  localparam int CNT_W  = $clog2(N_CH + 1);
  localparam int COOL_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic signed [SCORE_W-1:0] THR_POS = SCORE_W'(SCORE_THRESH);
  localparam logic signed [SCORE_W-1:0] THR_NEG = -THR_POS;
  localparam logic [CNT_W-1:0] CONF_CNT = CNT_W'(CONF_THRESH);

  typedef enum logic [1:0] {
    FLAT  = 2'b00,
    LONG  = 2'b01,
    SHORT = 2'b10
  } pos_t;

  // Input capture stage
  logic                   r_in_valid;
  logic [N_CH*DATA_W-1:0] r_in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_valid <= 1'b0;
      r_in_data  <= '0;
    end else begin
      r_in_valid <= in_valid;
      if (in_valid) r_in_data <= ma_data;
    end
  end

  // Scoring stage
  logic [DATA_W-1:0]         w_cur  [N_CH];
  logic [DATA_W-1:0]         r_prev [N_CH];
  logic                      w_rise [N_CH];
  logic                      w_fall [N_CH];
  logic signed [SCORE_W-1:0] w_diff [HALF];
  logic signed [SCORE_W-1:0] w_score;
  logic [CNT_W-1:0]          w_rise_cnt;
  logic [CNT_W-1:0]          w_fall_cnt;
  logic                      w_up;
  logic                      w_dn;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_cur[gi]  = r_in_data[gi*DATA_W +: DATA_W];
      assign w_rise[gi] = w_cur[gi] > r_prev[gi];
      assign w_fall[gi] = w_cur[gi] < r_prev[gi];
    end
    for (gi = 0; gi < HALF; gi++) begin : g_pair
      assign w_diff[gi] = $signed(SCORE_W'(w_cur[gi])) - $signed(SCORE_W'(w_cur[gi+HALF]));
    end
  endgenerate

  always_comb begin
    w_score    = '0;
    w_rise_cnt = '0;
    w_fall_cnt = '0;
    for (int i = 0; i < HALF; i++) w_score = w_score + w_diff[i];
    for (int i = 0; i < N_CH; i++) begin
      w_rise_cnt = w_rise_cnt + CNT_W'(w_rise[i]);
      w_fall_cnt = w_fall_cnt + CNT_W'(w_fall[i]);
    end
  end

  assign w_up = (w_score > THR_POS) && (w_rise_cnt >= CONF_CNT);
  assign w_dn = (w_score < THR_NEG) && (w_fall_cnt >= CONF_CNT);

  logic                      r_primed;
  logic                      r_s1_valid;
  logic signed [SCORE_W-1:0] r_s1_score;
  logic                      r_s1_up;
  logic                      r_s1_dn;

  // The first sample after reset only seeds prev; it never reaches the decision stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_primed   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_score <= '0;
      r_s1_up    <= 1'b0;
      r_s1_dn    <= 1'b0;
      for (int i = 0; i < N_CH; i++) r_prev[i] <= '0;
    end else begin
      r_s1_valid <= r_in_valid && r_primed;
      if (r_in_valid) begin
        r_primed   <= 1'b1;
        r_s1_score <= w_score;
        r_s1_up    <= w_up;
        r_s1_dn    <= w_dn;
        for (int i = 0; i < N_CH; i++) r_prev[i] <= w_cur[i];
      end
    end
  end

  // Decision stage
  pos_t              r_state;
  pos_t              w_state_next;
  logic [COOL_W-1:0] r_cool;
  logic [COOL_W-1:0] w_cool_next;
  logic              w_buy;
  logic              w_sell;
  logic              r_out_valid;
  logic              r_buy;
  logic              r_sell;
  logic signed [SCORE_W-1:0] r_score;

  always_comb begin
    w_state_next = r_state;
    w_buy        = 1'b0;
    w_sell       = 1'b0;
    if (r_s1_valid && (r_cool == '0)) begin
      case (r_state)
        FLAT: begin
          if (r_s1_up) begin
            w_state_next = LONG;
            w_buy        = 1'b1;
          end else if (r_s1_dn) begin
            w_state_next = SHORT;
            w_sell       = 1'b1;
          end
        end
        LONG: begin
          if (r_s1_dn) begin
            w_state_next = FLAT;
            w_sell       = 1'b1;
          end
        end
        SHORT: begin
          if (r_s1_up) begin
            w_state_next = FLAT;
            w_buy        = 1'b1;
          end
        end
        default: w_state_next = FLAT;
      endcase
    end
  end

  always_comb begin
    w_cool_next = r_cool;
    if (r_s1_valid) begin
      if (w_buy || w_sell)    w_cool_next = COOL_W'(COOLDOWN);
      else if (r_cool != '0) w_cool_next = r_cool - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FLAT;
      r_cool      <= '0;
      r_out_valid <= 1'b0;
      r_buy       <= 1'b0;
      r_sell      <= 1'b0;
      r_score     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cool      <= w_cool_next;
      r_out_valid <= r_s1_valid;
      r_buy       <= w_buy;
      r_sell      <= w_sell;
      if (r_s1_valid) r_score <= r_s1_score;
    end
  end

  assign out_valid  = r_out_valid;
  assign buy_pulse  = r_buy;
  assign sell_pulse = r_sell;
  assign position   = r_state;
  assign score      = r_score;

endmodule

// File: tb/tb_sma_signal_engine.sv
// Scoreboard bench for sma_signal_engine: expected decisions are queued at drive time
// and popped by a negedge monitor whenever out_valid strobes.
module tb_sma_signal_engine;

  localparam int SW = 12;

  typedef struct packed {
    logic                 buy;
    logic                 sell;
    logic [1:0]           pos;
    logic signed [SW-1:0] score;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic [47:0]          ma_data;
  logic                 out_valid;
  logic                 buy_pulse;
  logic                 sell_pulse;
  logic [1:0]           position;
  logic signed [SW-1:0] score;

  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  exp_t q[$];
  exp_t mon_e;

  sma_signal_engine #(
    .DATA_W(8), .N_CH(6), .SCORE_THRESH(77), .CONF_THRESH(3), .COOLDOWN(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ma_data(ma_data),
    .out_valid(out_valid), .buy_pulse(buy_pulse), .sell_pulse(sell_pulse),
    .position(position), .score(score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor
  always @(negedge clk) begin
    if (out_valid) begin
      n_out++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got out_valid=1 score=%0d, required no output", score);
      end else begin
        mon_e = q.pop_front();
        checks += 4;
        if (buy_pulse !== mon_e.buy) begin
          errors++;
          $display("FAIL buy_pulse: got %b, required %b", buy_pulse, mon_e.buy);
        end
        if (sell_pulse !== mon_e.sell) begin
          errors++;
          $display("FAIL sell_pulse: got %b, required %b", sell_pulse, mon_e.sell);
        end
        if (position !== mon_e.pos) begin
          errors++;
          $display("FAIL position: got %b, required %b", position, mon_e.pos);
        end
        if (score !== mon_e.score) begin
          errors++;
          $display("FAIL score: got %0d, required %0d", score, mon_e.score);
        end
        $display("out: buy=%b sell=%b pos=%b score=%0d", buy_pulse, sell_pulse, position, score);
      end
    end else begin
      checks++;
      if (buy_pulse || sell_pulse) begin
        errors++;
        $display("FAIL stray_pulse: got buy=%b sell=%b without out_valid, required 0", buy_pulse, sell_pulse);
      end
    end
  end

  function automatic logic [47:0] pack6(input int c0, c1, c2, c3, c4, c5);
    return {8'(c5), 8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  function automatic logic [47:0] pack(input int f, input int s);
    return pack6(f, f, f, s, s, s);
  endfunction

  task automatic send(input logic [47:0] d, input bit exp_out, input logic eb, input logic es,
                      input logic [1:0] ep, input int esc);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    ma_data  = d;
    if (exp_out) begin
      e.buy   = eb;
      e.sell  = es;
      e.pos   = ep;
      e.score = SW'(esc);
      q.push_back(e);
    end
  endtask

  task automatic stop_input();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d outputs still pending, required 0", q.size());
      q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    ma_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (position !== 2'b00) begin errors++; $display("FAIL reset_position: got %b, required 00", position); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (score !== 12'sd0)   begin errors++; $display("FAIL reset_score: got %0d, required 0", score); end
    if (buy_pulse !== 1'b0) begin errors++; $display("FAIL reset_buy: got %b, required 0", buy_pulse); end
    if (sell_pulse !== 1'b0) begin errors++; $display("FAIL reset_sell: got %b, required 0", sell_pulse); end
    $display("reset: pos=%b out_valid=%b score=%0d", position, out_valid, score);
    rst = 1'b0;
  endtask

  task automatic test_priming();
    int base = n_out;
    send(pack(100, 100), 0, 0, 0, 2'b00, 0);
    stop_input();
    drain();
    checks += 2;
    if (n_out != base) begin errors++; $display("FAIL priming_out_valid: got %0d outputs, required 0", n_out - base); end
    if (position !== 2'b00) begin errors++; $display("FAIL priming_position: got %b, required 00", position); end
    $display("priming: outputs=%0d pos=%b", n_out - base, position);
  endtask

  task automatic test_buy_entry();
    send(pack(140, 100), 1, 1, 0, 2'b01, 120);
    stop_input();
    drain();
    checks++;
    if (position !== 2'b01) begin errors++; $display("FAIL buy_hold_position: got %b, required 01", position); end
  endtask

  task automatic test_cooldown();
    send(pack(60, 100), 1, 0, 0, 2'b01, -120);
    send(pack(60, 100), 1, 0, 0, 2'b01, -120);
    send(pack(50, 100), 1, 0, 1, 2'b00, -150);
    send(pack(50, 100), 1, 0, 0, 2'b00, -150);
    send(pack(50, 100), 1, 0, 0, 2'b00, -150);
    stop_input();
    drain();
    checks++;
    if (position !== 2'b00) begin errors++; $display("FAIL cooldown_position: got %b, required 00", position); end
  endtask

  task automatic test_confluence();
    send(pack6(130, 130, 50, 100, 100, 20), 1, 0, 0, 2'b00, 90);
    send(pack6(140, 140, 50, 100, 100, 40), 1, 1, 0, 2'b01, 90);
    stop_input();
    drain();
  endtask

  task automatic test_wide_back_to_back();
    send(pack(255, 0), 1, 0, 0, 2'b01, 765);
    send(pack(0, 255), 1, 0, 0, 2'b01, -765);
    send(pack(0, 255), 1, 0, 0, 2'b01, -765);
    send(pack(0, 254), 1, 0, 1, 2'b00, -762);
    stop_input();
    drain();
  endtask

  task automatic test_reset_midflight();
    int base;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    ma_data  = pack(200, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    base = n_out;
    repeat (6) @(posedge clk);
    #1;
    checks += 3;
    if (n_out != base) begin errors++; $display("FAIL midflight_out_valid: got %0d outputs, required 0", n_out - base); end
    if (position !== 2'b00) begin errors++; $display("FAIL midflight_position: got %b, required 00", position); end
    if (score !== 12'sd0) begin errors++; $display("FAIL midflight_score: got %0d, required 0", score); end
    $display("midflight reset: outputs=%0d pos=%b", n_out - base, position);
    base = n_out;
    send(pack(100, 100), 0, 0, 0, 2'b00, 0);
    send(pack(140, 100), 1, 1, 0, 2'b01, 120);
    stop_input();
    drain();
    checks += 2;
    if (n_out != base + 1) begin errors++; $display("FAIL reprime_count: got %0d outputs, required 1", n_out - base); end
    if (position !== 2'b01) begin errors++; $display("FAIL reprime_position: got %b, required 01", position); end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    ma_data  = '0;
    test_reset();
    test_priming();
    test_buy_entry();
    test_cooldown();
    test_confluence();
    test_wide_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sma_signal_engine.md
# sma_signal_engine

Parametrised moving-average crossover and confluence signal engine with position tracking. It accepts one vector of N_CH moving-average samples per `in_valid`, scores fast-versus-slow spread and per-channel slope agreement, and drives a FLAT/LONG/SHORT position state machine. Entries and exits are qualified by a cooldown. It sits between the moving-average preprocessor and the order-entry logic, and emits one registered decision per accepted sample.

## Interface
- DATA_W, 8: unsigned width of each moving-average sample.
- N_CH, 6: channel count; must be even and ≥2. Channels 0..N_CH/2-1 are fast, N_CH/2..N_CH-1 are slow; index ascends with period.
- SCORE_THRESH, 77: non-negative spread threshold; must fit in SCORE_W-1 bits.
- CONF_THRESH, 3: minimum number of channels moving in the signal direction; range 1..N_CH.
- COOLDOWN, 4: number of accepted samples after any position change during which no transition is taken; 0 disables the cooldown.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  `ma_data` is sampled when this is high.
- ma_data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  1  one-cycle strobe, one per accepted sample once primed.
- buy_pulse  out  1  one-cycle strobe, qualified by `out_valid`.
- sell_pulse  out  1  one-cycle strobe, qualified by `out_valid`.
- position  out  2  00 = FLAT, 01 = LONG, 10 = SHORT; 11 is never driven.
- score  out  SCORE_W  signed spread registered with `out_valid`, where SCORE_W = DATA_W+1+$clog2(N_CH/2)+1.

## Operation
- **Stage 1 (on `in_valid`):**
  - Compute `score = Σ_{i<N_CH/2} (ma[i] − ma[i+N_CH/2])` in signed SCORE_W arithmetic, with no truncation or saturation.
  - `rise_cnt` = number of channels with `ma[i] > prev[i]`; `fall_cnt` = number with `ma[i] < prev[i]`. Both are unsigned, width $clog2(N_CH+1). Equal values count as neither.
  - Update `prev[i]` with `ma[i]` on every accepted sample.
- **Priming:**
  - The first accepted sample after reset only loads `prev`.
  - It produces no `out_valid` and no decision.
  - A `primed` flag is set by that sample.
- **Conditions:**
  - `up = score > SCORE_THRESH && rise_cnt >= CONF_THRESH`.
  - `dn = score < −SCORE_THRESH && fall_cnt >= CONF_THRESH`.
  - `up` and `dn` are mutually exclusive by construction.
- **Position FSM (Stage 2):** evaluated only on primed samples with `cool == 0`.
  - FLAT, `up` → LONG, `buy_pulse`.
  - FLAT, `dn` → SHORT, `sell_pulse`.
  - LONG, `dn` → FLAT, `sell_pulse` (exit). There is no direct flip to SHORT.
  - SHORT, `up` → FLAT, `buy_pulse` (cover).
  - All other cases: hold, no pulse.
- **Cooldown counter `cool`:**
  - Loaded with COOLDOWN on any transition.
  - Decremented by 1 on each subsequent primed sample while nonzero.
  - Samples arriving while `cool != 0` still update `prev` and still produce `out_valid` and `score`, but take no transition.
- **Reset (`rst` high):**
  - `position` = FLAT; `out_valid`, `buy_pulse`, `sell_pulse` = 0; `score` = 0.
  - `prev` = 0, `cool` = 0, `primed` = 0.
  - Reset takes priority over `in_valid` in the same cycle.
  - Reset mid-pipeline discards any in-flight sample; no output strobe follows it.

## Timing
- A sample accepted at edge t drives `out_valid`, pulses, the `position` update and `score` at edge t+2. Latency is fixed at 2 cycles.
- Full throughput: `in_valid` may be high every cycle, giving one decision per cycle.
- `position` changes only on the same edge as the corresponding pulse and holds between samples.
- Pulses are high for exactly one cycle. `buy_pulse` and `sell_pulse` are never high together.
- Gaps in `in_valid` stall nothing. `prev` always holds the last accepted sample, regardless of the gap length.

## Test plan
Defaults for all scenarios: N_CH=6, DATA_W=8, SCORE_THRESH=77, CONF_THRESH=3, COOLDOWN=2.

1. **Priming:** after reset, apply one sample of all 100 → no `out_valid` ever follows it; `position` = 00.
2. **Buy entry:** primed with all 100, then ma[0..2]=140 and ma[3..5]=100 → 2 cycles later `out_valid`=1, `score`=120, `buy_pulse`=1, `position`=01.
3. **Cooldown:** from test 2, the next sample is ma[0..2]=60, ma[3..5]=100 (score −120, fall_cnt 3) → no pulse, LONG held. Repeat the same input, which gives fall_cnt 0 → no pulse. A third sample of ma[0..2]=50 → `sell_pulse`, `position`=00.
4. **Confluence gate:** score = +90 with only 2 channels rising → `out_valid`=1, no pulse, FLAT held. The same score with 3 channels rising → buy.
5. **Wide arithmetic:** ma[0..2]=255, ma[3..5]=0 → `score` = +765 with no wrap. The inverse input → −765.
6. **Reset mid-flight:** assert `rst` one cycle after an entry-qualifying sample → no pulse and no `out_valid`. `position`=00, and the next sample after reset only primes.
